bp_be_issue_sequencer: RTL and testbench
========================================

Name: bp_be_issue_sequencer

Overview:
- Control-side sequencer for the BE issue queue.
- Turns dispatch, commit, flush and FE-redirect events into the queue's one-cycle op strobes: read, deq, roll, clr, suppress.
- Owns the redirect/suppress FSM and an in-flight (read-but-not-committed) counter.
- Sits between the BE checker/director and bp_be_issue_queue.

Parameters:
- fe_queue_fifo_els_p, 8, issue queue depth in entries; must be a power of 2.
- compressed_support_p, 0, 1 enables skip strobes for half-slot pointer stepping.
- settle_cycles_p, 2, cycles suppress stays high after FE acknowledges a redirect; 0 is allowed.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- issue_v_i  in  1  issue_pkt.v from the issue queue.
- dispatch_v_i  in  1  dispatch accepts the current issue packet.
- dispatch_skip_i  in  1  accepted instr is 32b under compressed support.
- commit_v_i  in  1  oldest in-flight instruction retires.
- commit_skip_i  in  1  retired instr is 32b under compressed support.
- flush_v_i  in  1  squash uncommitted instrs; replay from checkpoint.
- redirect_v_i  in  1  FE redirect; discard the entire queue.
- fe_cmd_yumi_i  in  1  FE accepted the redirect command.
- hold_i  in  1  temporary issue stall (interrupt pending, debug halt).
- read_v_o  out  1  to queue read_v_i.
- read_skip_o  out  1  to queue read_skip_i.
- deq_v_o  out  1  to queue deq_v_i.
- deq_skip_o  out  1  to queue deq_skip_i.
- roll_v_o  out  1  to queue roll_v_i.
- clr_v_o  out  1  to queue clr_v_i.
- suppress_v_o  out  1  to queue suppress_v_i.
- inflight_o  out  clog2(fe_queue_fifo_els_p+1)  count of read-but-uncommitted instrs.
- busy_o  out  1  FSM is not in RUN.
- protocol_err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, reset_n_i=0):
  - state=RUN, inflight=0, settle counter=0, protocol_err_o=0.
  - All strobes are combinational and read 0 during reset.
- Strobes are combinational from state and inputs; there is no added latency.
- Skip outputs equal the matching skip input gated by the matching valid. Skip outputs are tied to 0 when compressed_support_p=0.
- RUN, priority order (first match wins):
  1. redirect_v_i: clr_v_o=1, suppress_v_o=1; read, deq and roll forced to 0; next state WAIT_FE.
  2. flush_v_i: roll_v_o=1; deq_v_o=commit_v_i (the queue folds the same-cycle deq into the roll); read_v_o=0; stay in RUN.
  3. Otherwise:
     - read_v_o = issue_v_i & dispatch_v_i & ~hold_i.
     - deq_v_o = commit_v_i.
     - suppress_v_o = hold_i.
- WAIT_FE:
  - suppress_v_o=1; read_v_o=0, roll_v_o=0.
  - fe_cmd_yumi_i: go to SETTLE with counter loaded to settle_cycles_p-1, or go straight to RUN if settle_cycles_p=0.
- SETTLE:
  - suppress_v_o=1; counter decrements each cycle.
  - Counter reaching 0 → RUN on the next edge.
- redirect_v_i in WAIT_FE or SETTLE: clr_v_o=1 again, next state WAIT_FE; any counter value is discarded.
- Any of these in a non-RUN state sets protocol_err_o; deq_v_o and read_v_o are forced to 0 so the cleared pointers stay intact:
  - commit_v_i, or dispatch_v_i while issue_v_i=1.
- flush_v_i in a non-RUN state is ignored; the clear already dominates.
- Inflight counter, counted in instructions (a skip still counts as 1):
  - clr or roll → next = 0.
  - Otherwise next = inflight + read_v_o - deq_v_o.
- Further protocol_err_o conditions (the counter saturates at its bounds):
  - deq_v_o=1 while inflight=0 and read_v_o=0 (underflow).
  - read with inflight=fe_queue_fifo_els_p (overflow).
- protocol_err_o clears only on reset.
- busy_o = (state != RUN).
- Invariant: at most one of {clr_v_o, roll_v_o} per cycle; read_v_o=0 whenever clr_v_o or roll_v_o is 1.

Decomposition:
- bp_be_pkg gains enum bp_be_issue_seq_state_e {e_seq_run, e_seq_wait_fe, e_seq_settle}.
- Inflight count uses bsg_counter_up_down (an async-reset variant).
- Settle countdown is inline.
- No further sub-module.

Test Plan:
- Reset, then 3 dispatches and 2 commits: read_v_o pulses 3×, deq_v_o 2×, inflight_o ends at 1; protocol_err_o=0.
- inflight=3, flush_v_i & commit_v_i same cycle: roll_v_o=1, deq_v_o=1, read_v_o=0; next cycle inflight_o=0.
- redirect_v_i in RUN:
  - Same cycle: clr_v_o=1, suppress_v_o=1.
  - fe_cmd_yumi_i 4 cycles later, settle_cycles_p=2: suppress_v_o stays high exactly 2 more cycles, then busy_o=0.
- redirect_v_i again during SETTLE: clr_v_o re-pulses, state returns to WAIT_FE, suppress_v_o held until the next yumi.
- commit_v_i in WAIT_FE: deq_v_o=0, protocol_err_o=1 and remains set until reset_n_i low.
- hold_i=1 with issue_v_i & dispatch_v_i: read_v_o=0, suppress_v_o=1; deassert hold_i → read_v_o=1 same cycle.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared BE types: issue-sequencer FSM states and small width helpers.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_seq_run     = 2'd0,
        e_seq_wait_fe = 2'd1,
        e_seq_settle  = 2'd2
    } bp_be_issue_seq_state_e;

    // Minimum 1-bit width for a register holding values 0..n-1.
    function automatic int unsigned bp_be_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturating up/down counter with synchronous clear and async active-low reset.
// Latency: count_o reflects up/down/clear one edge later.
// Backpressure: none; out-of-range steps hold at the bound.
module bsg_counter_up_down #(
    parameter int max_val_p = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             clear_i,
    input  logic                             up_i,
    input  logic                             down_i,
    output logic [$clog2(max_val_p+1)-1:0]   count_o
);

    localparam int width_lp = $clog2(max_val_p + 1);
    localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

    logic [width_lp-1:0] count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i && !down_i && (count_r != max_lp)) begin
            count_r <= count_r + 1'b1;
        end else if (down_i && !up_i && (count_r != '0)) begin
            count_r <= count_r - 1'b1;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bp_be_issue_sequencer.sv
// Issue-queue control sequencer: maps dispatch/commit/flush/redirect onto queue op strobes.
// Latency: strobes are combinational from state and inputs (zero cycles).
// Backpressure: hold_i and the redirect/settle window suppress issue; no ready handshake.
module bp_be_issue_sequencer
    import bp_be_pkg::*;
#(
    parameter int fe_queue_fifo_els_p  = 8,
    parameter int compressed_support_p = 0,
    parameter int settle_cycles_p      = 2
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     issue_v_i,
    input  logic                                     dispatch_v_i,
    input  logic                                     dispatch_skip_i,
    input  logic                                     commit_v_i,
    input  logic                                     commit_skip_i,
    input  logic                                     flush_v_i,
    input  logic                                     redirect_v_i,
    input  logic                                     fe_cmd_yumi_i,
    input  logic                                     hold_i,
    output logic                                     read_v_o,
    output logic                                     read_skip_o,
    output logic                                     deq_v_o,
    output logic                                     deq_skip_o,
    output logic                                     roll_v_o,
    output logic                                     clr_v_o,
    output logic                                     suppress_v_o,
    output logic [$clog2(fe_queue_fifo_els_p+1)-1:0] inflight_o,
    output logic                                     busy_o,
    output logic                                     protocol_err_o
);

    localparam int inflight_w_lp = $clog2(fe_queue_fifo_els_p + 1);
    localparam int settle_w_lp   = bp_be_width(settle_cycles_p);
    localparam logic [settle_w_lp-1:0] settle_load_lp =
        (settle_cycles_p > 0) ? settle_w_lp'(settle_cycles_p - 1) : '0;
    localparam logic [inflight_w_lp-1:0] inflight_max_lp = inflight_w_lp'(fe_queue_fifo_els_p);
    localparam logic compressed_en_lp = (compressed_support_p != 0);

    bp_be_issue_seq_state_e state_r, state_n;
    logic [settle_w_lp-1:0] settle_cnt_r, settle_cnt_n;

    logic read_raw, deq_raw, roll_raw, clr_raw, suppress_raw, seq_err;
    logic err_set, protocol_err_r;
    logic [inflight_w_lp-1:0] inflight;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_seq_run;
            settle_cnt_r <= '0;
        end else begin
            state_r      <= state_n;
            settle_cnt_r <= settle_cnt_n;
        end
    end

    always_comb begin
        state_n      = state_r;
        settle_cnt_n = settle_cnt_r;
        read_raw     = 1'b0;
        deq_raw      = 1'b0;
        roll_raw     = 1'b0;
        clr_raw      = 1'b0;
        suppress_raw = 1'b0;
        seq_err      = 1'b0;

        case (state_r)
            e_seq_run: begin
                if (redirect_v_i) begin
                    clr_raw      = 1'b1;
                    suppress_raw = 1'b1;
                    state_n      = e_seq_wait_fe;
                end else if (flush_v_i) begin
                    // The queue folds a same-cycle deq into the roll.
                    roll_raw = 1'b1;
                    deq_raw  = commit_v_i;
                end else begin
                    read_raw     = issue_v_i & dispatch_v_i & ~hold_i;
                    deq_raw      = commit_v_i;
                    suppress_raw = hold_i;
                end
            end

            e_seq_wait_fe: begin
                suppress_raw = 1'b1;
                seq_err      = commit_v_i | (dispatch_v_i & issue_v_i);
                if (redirect_v_i) begin
                    clr_raw      = 1'b1;
                    settle_cnt_n = '0;
                end else if (fe_cmd_yumi_i) begin
                    if (settle_cycles_p == 0) begin
                        state_n = e_seq_run;
                    end else begin
                        state_n      = e_seq_settle;
                        settle_cnt_n = settle_load_lp;
                    end
                end
            end

            e_seq_settle: begin
                suppress_raw = 1'b1;
                seq_err      = commit_v_i | (dispatch_v_i & issue_v_i);
                if (redirect_v_i) begin
                    clr_raw      = 1'b1;
                    state_n      = e_seq_wait_fe;
                    settle_cnt_n = '0;
                end else if (settle_cnt_r == '0) begin
                    state_n = e_seq_run;
                end else begin
                    settle_cnt_n = settle_cnt_r - 1'b1;
                end
            end

            default: begin
                state_n      = e_seq_run;
                settle_cnt_n = '0;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted so the queue sees no ops.
    assign read_v_o     = reset_n_i & read_raw;
    assign deq_v_o      = reset_n_i & deq_raw;
    assign roll_v_o     = reset_n_i & roll_raw;
    assign clr_v_o      = reset_n_i & clr_raw;
    assign suppress_v_o = reset_n_i & suppress_raw;

    assign read_skip_o  = compressed_en_lp & read_v_o & dispatch_skip_i;
    assign deq_skip_o   = compressed_en_lp & deq_v_o & commit_skip_i;

    bsg_counter_up_down #(
        .max_val_p (fe_queue_fifo_els_p)
    ) u_inflight (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (clr_v_o | roll_v_o),
        .up_i      (read_v_o),
        .down_i    (deq_v_o),
        .count_o   (inflight)
    );

    assign err_set = seq_err
                   | (deq_v_o & ~read_v_o & (inflight == '0))
                   | (read_v_o & (inflight == inflight_max_lp));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            protocol_err_r <= 1'b0;
        end else if (err_set) begin
            protocol_err_r <= 1'b1;
        end
    end

    assign inflight_o     = inflight;
    assign protocol_err_o = protocol_err_r;
    assign busy_o         = (state_r != e_seq_run);

endmodule

// File: tb/tb_bp_be_issue_sequencer.sv
// Self-checking bench for bp_be_issue_sequencer: directed scenarios plus randomized run
// against a cycle-level behavioural model of the sequencing rules.
module tb_bp_be_issue_sequencer;

    localparam int DEPTH  = 8;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic issue_v, dispatch_v, dispatch_skip, commit_v, commit_skip;
    logic flush_v, redirect_v, yumi, hold;
    logic read_v, read_skip, deq_v, deq_skip, roll_v, clr_v, supp_v, busy, perr;
    logic [3:0] inflight;

    int checks = 0;
    int errors = 0;

    // Model state: awaiting FE ack, remaining settle cycles, inflight count, sticky error.
    bit m_wait;
    int m_settle;
    int m_inflight;
    bit m_err;
    bit e_read, e_rskip, e_deq, e_dskip, e_roll, e_clr, e_supp, e_busy;

    always #5 clk = ~clk;

    bp_be_issue_sequencer #(
        .fe_queue_fifo_els_p  (DEPTH),
        .compressed_support_p (1),
        .settle_cycles_p      (SETTLE)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .issue_v_i       (issue_v),
        .dispatch_v_i    (dispatch_v),
        .dispatch_skip_i (dispatch_skip),
        .commit_v_i      (commit_v),
        .commit_skip_i   (commit_skip),
        .flush_v_i       (flush_v),
        .redirect_v_i    (redirect_v),
        .fe_cmd_yumi_i   (yumi),
        .hold_i          (hold),
        .read_v_o        (read_v),
        .read_skip_o     (read_skip),
        .deq_v_o         (deq_v),
        .deq_skip_o      (deq_skip),
        .roll_v_o        (roll_v),
        .clr_v_o         (clr_v),
        .suppress_v_o    (supp_v),
        .inflight_o      (inflight),
        .busy_o          (busy),
        .protocol_err_o  (perr)
    );

    task automatic model_eval();
        bit running;
        running = !m_wait && (m_settle == 0);
        e_read = 0; e_deq = 0; e_roll = 0; e_clr = 0; e_supp = 0;
        e_busy = !running;
        if (running) begin
            if (redirect_v) begin
                e_clr = 1; e_supp = 1;
            end else if (flush_v) begin
                e_roll = 1; e_deq = commit_v;
            end else begin
                e_read = issue_v && dispatch_v && !hold;
                e_deq  = commit_v;
                e_supp = hold;
            end
        end else begin
            e_supp = 1;
            e_clr  = redirect_v;
        end
        e_rskip = e_read && dispatch_skip;
        e_dskip = e_deq && commit_skip;
    endtask

    task automatic model_step();
        model_eval();
        if ((e_busy && (commit_v || (dispatch_v && issue_v))) ||
            (e_deq && !e_read && m_inflight == 0) ||
            (e_read && m_inflight == DEPTH))
            m_err = 1;
        if (e_clr || e_roll) begin
            m_inflight = 0;
        end else begin
            m_inflight = m_inflight + int'(e_read) - int'(e_deq);
            if (m_inflight < 0) m_inflight = 0;
            if (m_inflight > DEPTH) m_inflight = DEPTH;
        end
        if (redirect_v) begin
            m_wait = 1; m_settle = 0;
        end else if (m_wait) begin
            if (yumi) begin
                m_wait = 0; m_settle = SETTLE;
            end
        end else if (m_settle > 0) begin
            m_settle = m_settle - 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        issue_v = 0; dispatch_v = 0; dispatch_skip = 0; commit_v = 0; commit_skip = 0;
        flush_v = 0; redirect_v = 0; yumi = 0; hold = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 0;
        @(posedge clk);
        #2;
        m_wait = 0; m_settle = 0; m_inflight = 0; m_err = 0;
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        issue_v = 1; dispatch_v = 1; dispatch_skip = 1; commit_v = 1; commit_skip = 1;
        flush_v = 1; redirect_v = 1; yumi = 1; hold = 1;
        reset_n = 0;
        #3;
        checks++;
        if ({read_v, read_skip, deq_v, deq_skip, roll_v, clr_v, supp_v} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000000",
                     {read_v, read_skip, deq_v, deq_skip, roll_v, clr_v, supp_v});
        end
        @(posedge clk);
        #2;
        checks++;
        if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (perr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", perr); end
        do_reset();
    endtask

    task automatic test_dispatch_commit();
        int reads = 0;
        int deqs = 0;
        for (int i = 0; i < 5; i++) begin
            set_idle();
            if (i < 3) begin issue_v = 1; dispatch_v = 1; end
            else commit_v = 1;
            #1;
            checks++;
            if (read_v !== (i < 3) || deq_v !== (i >= 3)) begin
                errors++;
                $display("FAIL dc_strobe step %0d got read=%b deq=%b want read=%b deq=%b",
                         i, read_v, deq_v, (i < 3), (i >= 3));
            end
            reads += int'(read_v);
            deqs += int'(deq_v);
            tick();
        end
        set_idle();
        #1;
        checks++;
        if (reads != 3 || deqs != 2) begin
            errors++;
            $display("FAIL dc_pulses got reads=%0d deqs=%0d want 3 2", reads, deqs);
        end
        checks++;
        if (inflight !== 4'd1) begin errors++; $display("FAIL dc_inflight got %0d want 1", inflight); end
        checks++;
        if (perr !== 1'b0) begin errors++; $display("FAIL dc_err got %b want 0", perr); end
    endtask

    task automatic test_flush_commit();
        for (int i = 0; i < 2; i++) begin
            set_idle(); issue_v = 1; dispatch_v = 1;
            tick();
        end
        set_idle();
        #1;
        checks++;
        if (inflight !== 4'd3) begin errors++; $display("FAIL flush_pre_inflight got %0d want 3", inflight); end
        flush_v = 1; commit_v = 1; issue_v = 1; dispatch_v = 1;
        #1;
        checks++;
        if ({roll_v, deq_v, read_v, clr_v} !== 4'b1100) begin
            errors++;
            $display("FAIL flush_strobes got roll/deq/read/clr=%b want 1100", {roll_v, deq_v, read_v, clr_v});
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (inflight !== 4'd0) begin errors++; $display("FAIL flush_inflight got %0d want 0", inflight); end
    endtask

    task automatic test_redirect_settle();
        int n = 0;
        set_idle(); redirect_v = 1; issue_v = 1; dispatch_v = 1;
        #1;
        checks++;
        if ({clr_v, supp_v, read_v, roll_v} !== 4'b1100) begin
            errors++;
            $display("FAIL redir_strobes got clr/supp/read/roll=%b want 1100", {clr_v, supp_v, read_v, roll_v});
        end
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            yumi = (i == 3);
            #1;
            checks++;
            if (supp_v !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL redir_wait cycle %0d got supp=%b busy=%b want 1 1", i, supp_v, busy);
            end
            tick();
        end
        set_idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!busy) break;
            if (supp_v) n++;
            tick();
        end
        checks++;
        if (n != SETTLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL redir_settle got supp_cycles=%0d busy=%b want %0d 0", n, busy, SETTLE);
        end
    endtask

    task automatic test_redirect_in_settle();
        set_idle(); redirect_v = 1; tick();
        set_idle(); yumi = 1; tick();
        set_idle(); redirect_v = 1;
        #1;
        checks++;
        if (clr_v !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resettle_clr got clr=%b busy=%b want 1 1", clr_v, busy);
        end
        tick();
        set_idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (supp_v !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL resettle_hold cycle %0d got supp=%b busy=%b want 1 1", i, supp_v, busy);
            end
            tick();
        end
        yumi = 1; tick();
        set_idle(); tick(); tick();
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL resettle_exit got busy=%b want 0", busy); end
    endtask

    task automatic test_hold();
        set_idle(); issue_v = 1; dispatch_v = 1; dispatch_skip = 1; hold = 1;
        #1;
        checks++;
        if ({read_v, read_skip, supp_v} !== 3'b001) begin
            errors++;
            $display("FAIL hold_on got read/skip/supp=%b want 001", {read_v, read_skip, supp_v});
        end
        hold = 0;
        #1;
        checks++;
        if ({read_v, read_skip, supp_v} !== 3'b110) begin
            errors++;
            $display("FAIL hold_off got read/skip/supp=%b want 110", {read_v, read_skip, supp_v});
        end
        tick();
        set_idle();
    endtask

    task automatic test_protocol_err();
        #1;
        checks++;
        if (perr !== 1'b0) begin errors++; $display("FAIL perr_pre got %b want 0", perr); end
        redirect_v = 1; tick();
        set_idle(); commit_v = 1;
        #1;
        checks++;
        if (deq_v !== 1'b0) begin errors++; $display("FAIL perr_deq got %b want 0", deq_v); end
        tick();
        set_idle();
        #1;
        checks++;
        if (perr !== 1'b1) begin errors++; $display("FAIL perr_set got %b want 1", perr); end
        yumi = 1; tick();
        set_idle();
        for (int i = 0; i < 6; i++) tick();
        #1;
        checks++;
        if (perr !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL perr_sticky got err=%b busy=%b want 1 0", perr, busy);
        end
        do_reset();
        checks++;
        if (perr !== 1'b0) begin errors++; $display("FAIL perr_clear got %b want 0", perr); end
    endtask

    task automatic test_bounds();
        set_idle(); commit_v = 1;
        #1;
        tick();
        set_idle();
        #1;
        checks++;
        if (perr !== 1'b1 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL underflow got err=%b inflight=%0d want 1 0", perr, inflight);
        end
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            issue_v = 1; dispatch_v = 1; tick();
        end
        #1;
        checks++;
        if (perr !== 1'b0 || inflight !== 4'(DEPTH)) begin
            errors++;
            $display("FAIL full got err=%b inflight=%0d want 0 %0d", perr, inflight, DEPTH);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (perr !== 1'b1 || inflight !== 4'(DEPTH)) begin
            errors++;
            $display("FAIL overflow got err=%b inflight=%0d want 1 %0d", perr, inflight, DEPTH);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            issue_v       = 1'($urandom_range(0, 1));
            dispatch_v    = 1'($urandom_range(0, 1));
            dispatch_skip = 1'($urandom_range(0, 1));
            commit_v      = ($urandom_range(0, 2) == 0) && (m_inflight > 0 || $urandom_range(0, 60) == 0);
            commit_skip   = 1'($urandom_range(0, 1));
            flush_v       = ($urandom_range(0, 19) == 0);
            redirect_v    = ($urandom_range(0, 23) == 0);
            yumi          = ($urandom_range(0, 2) == 0);
            hold          = ($urandom_range(0, 5) == 0);
            #1;
            model_eval();
            checks++;
            if ({read_v, read_skip, deq_v, deq_skip, roll_v, clr_v, supp_v, busy} !==
                {e_read, e_rskip, e_deq, e_dskip, e_roll, e_clr, e_supp, e_busy}) begin
                errors++;
                $display("FAIL rand_strobes cycle %0d got %b want %b", i,
                         {read_v, read_skip, deq_v, deq_skip, roll_v, clr_v, supp_v, busy},
                         {e_read, e_rskip, e_deq, e_dskip, e_roll, e_clr, e_supp, e_busy});
            end
            checks++;
            if (inflight !== 4'(m_inflight) || perr !== m_err) begin
                errors++;
                $display("FAIL rand_state cycle %0d got inflight=%0d err=%b want %0d %b",
                         i, inflight, perr, m_inflight, m_err);
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        set_idle();
        m_wait = 0; m_settle = 0; m_inflight = 0; m_err = 0;
        test_reset();
        test_dispatch_commit();
        test_flush_commit();
        test_redirect_settle();
        test_redirect_in_settle();
        test_hold();
        test_protocol_err();
        test_bounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
